// File: rtl/keypad_scan_debounce.sv
// Keypad front end: two-flop synchroniser, debounce, multi-key rejection, BCD digit + strobe, digit counter.
// Optional auto-repeat while a key stays held is built only when KEYPAD_AUTO_REPEAT_EN is defined.
module keypad_scan_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CODE_LEN        = 8,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] keys,
   input  logic       clear,
   output logic [3:0] key_digit,
   output logic       key_strobe,
   output logic       key_held,
   output logic       multi_err,
   output logic [3:0] digit_count,
   output logic       code_full
);

   // state  | meaning
   // IDLE   | nothing accepted, waiting for a stable non-zero key vector
   // HELD   | single key accepted and still stably pressed
   // REJECT | multi-key or changed vector seen, waiting for full release
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REJECT = 2'd2
   } state_t;

   generate
      if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 7 || CODE_LEN < 1 || CODE_LEN > 15 ||
          REPEAT_CYCLES < 2) begin : g_param_check
         $error("keypad_scan_debounce: parameter out of range");
      end
   endgenerate

   state_t     state;
   state_t     state_nxt;
   logic [9:0] s1;
   logic [9:0] s2;
   logic [9:0] last;
   logic [9:0] stable;
   logic [2:0] dcnt;
   logic [3:0] stable_idx;
   logic [9:0] held_vec;
   logic       stable_any;
   logic       stable_single;
   logic       held_match;
   logic       strobe_raw;
   logic       load_digit;
   logic       rpt_due;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= '0;
         s2     <= '0;
         last   <= '0;
         dcnt   <= '0;
         stable <= '0;
      end else begin
         s1   <= keys;
         s2   <= s1;
         last <= s2;
         if (s2 != last) begin
            dcnt <= '0;
         end else if (dcnt != 3'(DEBOUNCE_CYCLES)) begin
            dcnt <= dcnt + 3'd1;
         end
         if (s2 == last && dcnt == 3'(DEBOUNCE_CYCLES - 1)) begin
            stable <= s2;
         end
      end
   end

   always_comb begin
      stable_idx = '0;
      for (int i = 0; i < 10; i++) begin
         if (stable[i]) begin
            stable_idx = 4'(i);
         end
      end
   end

   assign stable_any    = |stable;
   assign stable_single = stable_any && ((stable & (stable - 10'd1)) == 10'd0);
   // key_digit only loads on IDLE->HELD, so in HELD it names the accepted key
   assign held_vec      = 10'd1 << key_digit;
   assign held_match    = (stable == held_vec);

`ifdef KEYPAD_AUTO_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES);
   logic [RPT_W-1:0] rpt_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt <= '0;
      end else if (state != HELD || rpt_cnt == '0) begin
         rpt_cnt <= RPT_W'(REPEAT_CYCLES - 1);
      end else begin
         rpt_cnt <= rpt_cnt - RPT_W'(1);
      end
   end

   assign rpt_due = held_match && (rpt_cnt == '0);
`else
   assign rpt_due = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      strobe_raw = 1'b0;
      multi_err  = 1'b0;
      load_digit = 1'b0;
      case (state)
         IDLE: begin
            if (stable_single) begin
               strobe_raw = 1'b1;
               load_digit = 1'b1;
               state_nxt  = HELD;
            end else if (stable_any) begin
               multi_err = 1'b1;
               state_nxt = REJECT;
            end
         end
         HELD: begin
            if (!stable_any) begin
               state_nxt = IDLE;
            end else if (!held_match) begin
               multi_err = !stable_single;
               state_nxt = REJECT;
            end else begin
               strobe_raw = rpt_due;
            end
         end
         REJECT: begin
            if (!stable_any) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign key_held   = (state == HELD) && held_match;
   assign code_full  = (digit_count == 4'(CODE_LEN));
   // clear and a full code both swallow the strobe; the FSM still tracks the press
   assign key_strobe = strobe_raw && !code_full && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_digit <= '0;
      end else if (load_digit) begin
         key_digit <= stable_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_count <= '0;
      end else if (clear) begin
         digit_count <= '0;
      end else if (key_strobe) begin
         digit_count <= digit_count + 4'd1;
      end
   end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: directed scenarios plus random key traffic, compared every cycle
// against an event-level model built from the sampled key history.
module tb_keypad_scan_debounce;

   localparam int DB  = 4;
   localparam int CL  = 8;
   localparam int RPT = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] keys  = '0;
   logic       clear = 1'b0;
   logic [3:0] key_digit;
   logic       key_strobe;
   logic       key_held;
   logic       multi_err;
   logic [3:0] digit_count;
   logic       code_full;

   keypad_scan_debounce #(
      .DEBOUNCE_CYCLES(DB),
      .CODE_LEN       (CL),
      .REPEAT_CYCLES  (RPT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .keys       (keys),
      .clear      (clear),
      .key_digit  (key_digit),
      .key_strobe (key_strobe),
      .key_held   (key_held),
      .multi_err  (multi_err),
      .digit_count(digit_count),
      .code_full  (code_full)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp, $time);
   endtask

   // reference model: key history window, settled vector, press bookkeeping
   logic [9:0] m_hist [12];
   logic [9:0] m_stable;
   bit         m_active;
   bit         m_locked;
   int         m_age;
   int         m_count;
   logic [3:0] m_digit;
   bit         m_raw;
   bit         m_merr;
   bit         m_load;
   logic [3:0] m_load_val;
   bit         e_strobe;

   logic [9:0] d_keys  = '0;
   logic       d_clear = 1'b0;
   logic       d_rst   = 1'b0;

   int seg_edges;
   int seg_strobes;
   int seg_merr;
   int first_strobe;

   task automatic model_reset();
      for (int i = 0; i < 12; i++) m_hist[i] = '0;
      m_stable = '0;
      m_active = 0;
      m_locked = 0;
      m_age    = 0;
      m_count  = 0;
      m_digit  = '0;
      m_raw    = 0;
      m_merr   = 0;
      m_load   = 0;
      m_load_val = '0;
      e_strobe = 0;
   endtask

   task automatic model_edge();
      bit         settled;
      logic [9:0] nv;
      if (clear) m_count = 0;
      else if (e_strobe) m_count++;
      if (m_load) m_digit = m_load_val;
      for (int i = 11; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = keys;
      if (m_active) m_age++;
      m_raw  = 0;
      m_merr = 0;
      m_load = 0;
      // a vector is settled once DB+1 consecutive synchronised samples agree
      settled = 1;
      for (int i = 3; i <= DB + 2; i++) if (m_hist[i] != m_hist[2]) settled = 0;
      if (settled && m_hist[2] != m_stable) begin
         nv = m_hist[2];
         if (nv == 0) begin
            m_active = 0;
            m_locked = 0;
         end else if (m_active || m_locked) begin
            if (m_active && $countones(nv) > 1) m_merr = 1;
            m_active = 0;
            m_locked = 1;
         end else if ($countones(nv) == 1) begin
            m_raw    = 1;
            m_load   = 1;
            for (int i = 0; i < 10; i++) if (nv[i]) m_load_val = 4'(i);
            m_active = 1;
            m_age    = 0;
         end else begin
            m_merr   = 1;
            m_locked = 1;
         end
         m_stable = nv;
      end
`ifdef KEYPAD_AUTO_REPEAT_EN
      if (m_active && m_age > 0 && (m_age % RPT) == 0) m_raw = 1;
`endif
   endtask

   task automatic step();
      @(negedge clk);
      keys  = d_keys;
      clear = d_clear;
      rst_n = d_rst;
      #1;
      e_strobe = m_raw && (m_count != CL) && !clear;
      check("key_strobe", key_strobe, e_strobe);
      check("multi_err", multi_err, m_merr);
      check("key_held", key_held, (m_active && m_age >= 1));
      check("key_digit", key_digit, m_digit);
      check("digit_count", digit_count, m_count);
      check("code_full", code_full, (m_count == CL));
      if (key_strobe === 1'b1) begin
         seg_strobes++;
         if (first_strobe < 0) first_strobe = seg_edges;
      end
      if (multi_err === 1'b1) seg_merr++;
      @(posedge clk);
      if (rst_n) model_edge();
      seg_edges++;
   endtask

   task automatic seg_start();
      seg_edges    = 0;
      seg_strobes  = 0;
      seg_merr     = 0;
      first_strobe = -1;
   endtask

   task automatic hold(input logic [9:0] k, input int n);
      d_keys = k;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic press(input logic [9:0] k, input int n_on, input int n_off);
      hold(k, n_on);
      hold('0, n_off);
   endtask

   logic [9:0] rv;
   int         ra;
   int         rb;
   int         rlen;

   initial begin
      model_reset();
      seg_start();
      d_rst = 1'b0;
      hold('0, 3);
      #1;
      check("rst_digit", key_digit, 0);
      check("rst_count", digit_count, 0);
      check("rst_strobe", key_strobe, 0);

      d_rst = 1'b1;
      hold('0, 5);

      // clean press of key 2
      seg_start();
      hold(10'b0000000100, 10);
      #1;
      check("t1_held", key_held, 1);
      hold('0, 10);
      #1;
      check("t1_strobes", seg_strobes, 1);
      check("t1_latency", first_strobe, DB + 3);
      check("t1_digit", key_digit, 2);
      check("t1_count", digit_count, 1);
      check("t1_released", key_held, 0);

      // glitch shorter than the debounce window
      seg_start();
      press(10'b0000100000, 3, 12);
      #1;
      check("t2_strobes", seg_strobes, 0);
      check("t2_merr", seg_merr, 0);
      check("t2_count", digit_count, 1);

      // two keys together, then a clean key 3
      seg_start();
      press(10'b1000000010, 10, 10);
      #1;
      check("t3_merr", seg_merr, 1);
      check("t3_strobes", seg_strobes, 0);
      seg_start();
      press(10'b0000001000, 10, 10);
      #1;
      check("t3_k3_strobes", seg_strobes, 1);
      check("t3_k3_digit", key_digit, 3);
      check("t3_k3_count", digit_count, 2);

      // fill the code: eight strobes then the ninth press is swallowed
      d_clear = 1'b1;
      step();
      d_clear = 1'b0;
      seg_start();
      press(10'd1 << 2, 10, 10);
      press(10'd1 << 1, 10, 10);
      press(10'd1 << 9, 10, 10);
      press(10'd1 << 3, 10, 10);
      press(10'd1 << 5, 10, 10);
      press(10'd1 << 4, 10, 10);
      press(10'd1 << 8, 10, 10);
      press(10'd1 << 7, 10, 10);
      press(10'd1 << 6, 10, 10);
      #1;
      check("t4_strobes", seg_strobes, 8);
      check("t4_count", digit_count, 8);
      check("t4_full", code_full, 1);
      check("t4_digit", key_digit, 6);

      // clear lands on the cycle the strobe is due
      d_clear = 1'b1;
      step();
      d_clear = 1'b0;
      seg_start();
      hold(10'd1 << 7, DB + 3);
      d_clear = 1'b1;
      step();
      d_clear = 1'b0;
      hold(10'd1 << 7, 2);
      hold('0, 10);
      #1;
      check("t5_strobes", seg_strobes, 0);
      check("t5_count", digit_count, 0);
      seg_start();
      press(10'd1 << 8, 10, 10);
      #1;
      check("t5_next_count", digit_count, 1);

      // reset while key 4 is held
      hold(10'd1 << 4, 10);
      #2;
      rst_n = 1'b0;
      d_rst = 1'b0;
      #1;
      model_reset();
      check("t6_rst_digit", key_digit, 0);
      check("t6_rst_count", digit_count, 0);
      check("t6_rst_held", key_held, 0);
      check("t6_rst_strobe", key_strobe, 0);
      hold(10'd1 << 4, 3);
      d_rst = 1'b1;
      seg_start();
      hold(10'd1 << 4, 50);
      #1;
`ifdef KEYPAD_AUTO_REPEAT_EN
      check("t6_strobes", seg_strobes, 3);
`else
      check("t6_strobes", seg_strobes, 1);
`endif
      check("t6_digit", key_digit, 4);
      hold('0, 10);

      // random key traffic with occasional clears
      for (int s = 0; s < 150; s++) begin
         ra = $urandom_range(0, 9);
         rb = (ra + $urandom_range(1, 9)) % 10;
         case ($urandom_range(0, 9))
            0, 1, 2, 3: rv = '0;
            8, 9:       rv = (10'd1 << ra) | (10'd1 << rb);
            default:    rv = 10'd1 << ra;
         endcase
         rlen = $urandom_range(1, 12);
         d_keys = rv;
         for (int i = 0; i < rlen; i++) begin
            d_clear = ($urandom_range(0, 19) == 0);
            step();
         end
      end
      d_clear = 1'b0;
      hold('0, 12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
